// File: rtl/cmp_stat_unit.sv
// cmp_stat_unit: counts one-hot comparator relation samples, tracks runs of equal relations, flags illegal samples
module cmp_stat_unit #(
   parameter int CNT_W   = 8,
   parameter int RUN_LEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             a_gt_b,
   input  logic             a_eq_b,
   input  logic             a_ls_b,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_gt,
   output logic [CNT_W-1:0] cnt_eq,
   output logic [CNT_W-1:0] cnt_ls,
   output logic [1:0]       run_state,
   output logic             run_match,
   output logic             out_valid,
   output logic             err
);
   typedef enum logic [1:0] {IDLE = 2'b00, GT = 2'b01, EQ = 2'b10, LS = 2'b11} state_t;
   localparam logic [3:0]       RL  = 4'(RUN_LEN);
   localparam logic [CNT_W-1:0] MAX = '1;
   state_t           state_q, state_d, rel;
   logic [3:0]       run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] gt_q, gt_d, eq_q, eq_d, ls_q, ls_d;
   logic             match_q, match_d, ov_q, ov_d, err_q, err_d;
   logic             one_hot, acc, ill;
   always_comb begin
      one_hot   = $onehot({a_gt_b, a_eq_b, a_ls_b});
      acc       = in_valid & ~clr & one_hot;
      ill       = in_valid & ~clr & ~one_hot;
      rel       = a_gt_b ? GT : a_eq_b ? EQ : LS;
      gt_d      = clr ? '0 : (acc && rel == GT && gt_q != MAX) ? gt_q + 1'b1 : gt_q;
      eq_d      = clr ? '0 : (acc && rel == EQ && eq_q != MAX) ? eq_q + 1'b1 : eq_q;
      ls_d      = clr ? '0 : (acc && rel == LS && ls_q != MAX) ? ls_q + 1'b1 : ls_q;
      state_d   = (clr || ill) ? IDLE : acc ? rel : state_q;
      // a new relation (including the first after IDLE) always restarts the run at 1
      run_cnt_d = (clr || ill) ? 4'd0 : !acc ? run_cnt_q : rel != state_q ? 4'd1 :
                  run_cnt_q == RL ? RL : run_cnt_q + 4'd1;
      match_d   = acc && rel == state_q && run_cnt_q == RL - 4'd1;
      ov_d      = acc;
      err_d     = !clr && (err_q || ill);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gt_q      <= '0;
         eq_q      <= '0;
         ls_q      <= '0;
         state_q   <= IDLE;
         run_cnt_q <= 4'd0;
         match_q   <= 1'b0;
         ov_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         gt_q      <= gt_d;
         eq_q      <= eq_d;
         ls_q      <= ls_d;
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
         match_q   <= match_d;
         ov_q      <= ov_d;
         err_q     <= err_d;
      end
   end
   assign cnt_gt    = gt_q;
   assign cnt_eq    = eq_q;
   assign cnt_ls    = ls_q;
   assign run_state = state_q;
   assign run_match = match_q;
   assign out_valid = ov_q;
   assign err       = err_q;
endmodule

// File: tb/tb_cmp_stat_unit.sv
// tb_cmp_stat_unit: scoreboard bench with a counting/run-length reference model, two counter widths
module tb_cmp_stat_unit;
   localparam int RL = 3;
   logic clk = 0, rst_n = 0, in_valid = 0, g = 0, e = 0, l = 0, clr = 0;
   logic [7:0] cg, ce, cl;
   logic [1:0] c2g, c2e, c2l, rs, rs2;
   logic rm, rm2, ov, ov2, er, er2;

   cmp_stat_unit #(.CNT_W(8), .RUN_LEN(RL)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_gt_b(g), .a_eq_b(e), .a_ls_b(l), .clr(clr),
      .cnt_gt(cg), .cnt_eq(ce), .cnt_ls(cl), .run_state(rs), .run_match(rm), .out_valid(ov), .err(er));
   cmp_stat_unit #(.CNT_W(2), .RUN_LEN(RL)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_gt_b(g), .a_eq_b(e), .a_ls_b(l), .clr(clr),
      .cnt_gt(c2g), .cnt_eq(c2e), .cnt_ls(c2l), .run_state(rs2), .run_match(rm2), .out_valid(ov2), .err(er2));

   always #5 clk = ~clk;

   typedef struct {int g, e, l, g2, e2, l2, st, rc, m, er;} rec_t;
   rec_t q[$];
   rec_t x;
   int errors = 0, checks = 0;
   int mc[3], mc2[3];
   int m_st, m_len, m_match, m_ov, m_err;

   function automatic void cmp(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endfunction

   function automatic rec_t snap();
      rec_t r;
      r.g = mc[0]; r.e = mc[1]; r.l = mc[2];
      r.g2 = mc2[0]; r.e2 = mc2[1]; r.l2 = mc2[2];
      r.st = m_st; r.rc = m_len > RL ? RL : m_len; r.m = m_match; r.er = m_err;
      return r;
   endfunction

   function automatic void mreset();
      mc = '{0, 0, 0}; mc2 = '{0, 0, 0};
      m_st = 0; m_len = 0; m_match = 0; m_ov = 0; m_err = 0;
   endfunction

   // f = {gt, eq, ls}; model advances to the state the DUT shows after the next edge
   task automatic cyc(input bit iv, input bit [2:0] f, input bit c);
      int r;
      in_valid = iv; {g, e, l} = f; clr = c;
      m_match = 0; m_ov = 0;
      if (c) mreset();
      else if (iv) begin
         if ($onehot(f)) begin
            r = f[2] ? 1 : f[1] ? 2 : 3;
            mc[r-1]  = mc[r-1] == 255 ? 255 : mc[r-1] + 1;
            mc2[r-1] = mc2[r-1] == 3 ? 3 : mc2[r-1] + 1;
            if (r == m_st) m_len++;
            else begin m_st = r; m_len = 1; end
            m_match = (m_len == RL);
            m_ov = 1;
            q.push_back(snap());
         end else begin
            m_err = 1; m_st = 0; m_len = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string n);
      rec_t r;
      r = snap();
      cmp({n, ".cnt_gt"}, cg, r.g);
      cmp({n, ".cnt_eq"}, ce, r.e);
      cmp({n, ".cnt_ls"}, cl, r.l);
      cmp({n, ".cnt2_gt"}, c2g, r.g2);
      cmp({n, ".cnt2_eq"}, c2e, r.e2);
      cmp({n, ".cnt2_ls"}, c2l, r.l2);
      cmp({n, ".run_state"}, rs, r.st);
      cmp({n, ".run_cnt"}, dut.run_cnt_q, r.rc);
      cmp({n, ".run_match"}, rm, r.m);
      cmp({n, ".out_valid"}, ov, m_ov);
      cmp({n, ".err"}, er, r.er);
   endtask

   always @(negedge clk) if (rst_n) begin
      cmp("sb.ov2_vs_ov", ov2, ov);
      if (ov) begin
         if (q.size() == 0) cmp("sb.unexpected_out_valid", 1, 0);
         else begin
            x = q.pop_front();
            cmp("sb.cnt_gt", cg, x.g);
            cmp("sb.cnt_eq", ce, x.e);
            cmp("sb.cnt_ls", cl, x.l);
            cmp("sb.cnt2_ls", c2l, x.l2);
            cmp("sb.cnt2_gt", c2g, x.g2);
            cmp("sb.run_state", rs, x.st);
            cmp("sb.run_cnt", dut.run_cnt_q, x.rc);
            cmp("sb.run_match", rm, x.m);
            cmp("sb.err", er, x.er);
         end
      end else cmp("sb.match_without_valid", rm, 0);
   end

   initial begin
      int rel;
      bit [2:0] f;
      mreset();
      #2 chk("reset");
      #1 rst_n = 1;
      @(posedge clk);
      #1;
      cyc(1, 3'b100, 0); cyc(1, 3'b010, 0); cyc(1, 3'b001, 0); cyc(1, 3'b010, 0);
      chk("mixed4");
      cyc(0, 3'b111, 0);
      chk("idle_garbage");
      cyc(1, 3'b000, 1);
      chk("clr");
      for (int i = 0; i < 5; i++) begin
         cyc(1, 3'b010, 0);
         chk($sformatf("eq_run%0d", i));
      end
      cyc(1, 3'b000, 1);
      cyc(1, 3'b100, 0); cyc(1, 3'b100, 0); cyc(1, 3'b110, 0);
      chk("illegal");
      cyc(1, 3'b100, 0);
      chk("after_illegal");
      repeat (3) cyc(0, 3'b000, 0);
      chk("err_sticky");
      cyc(1, 3'b000, 1);
      repeat (5) cyc(1, 3'b001, 0);
      chk("sat_w2");
      cyc(1, 3'b100, 1);
      chk("clr_vs_valid");
      cyc(1, 3'b010, 0); cyc(1, 3'b010, 0);
      #1 rst_n = 0;
      mreset();
      q.delete();
      #1 chk("async_rst");
      #1 rst_n = 1;
      cyc(1, 3'b010, 0);
      chk("post_rst");
      cyc(1, 3'b000, 1);
      repeat (258) cyc(1, 3'b100, 0);
      chk("sat_w8");
      cyc(1, 3'b000, 1);
      rel = 1;
      repeat (400) begin
         if ($urandom % 10 < 3) rel = 1 + $urandom % 3;
         f = 3'b100 >> (rel - 1);
         if ($urandom % 10 < 2) f = 3'($urandom % 8);
         cyc($urandom % 5 != 0, f, $urandom % 30 == 0);
      end
      chk("random_end");
      cyc(0, 3'b000, 0); cyc(0, 3'b000, 0);
      cmp("sb.drain", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cmp_stat_unit.md
CMP_STAT_UNIT -- requirements
Module: cmp_stat_unit

Interface
REQ-001 The block SHALL expose parameter CNT_W, default 8, giving the width of each event counter.
REQ-002 The block SHALL expose parameter RUN_LEN, default 3, legal range 2..15, giving the consecutive-relation length that raises run_match.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  qualifies the three relation flags in the current cycle.
REQ-007 a_gt_b  input  1  upstream 2-bit comparator flag: a > b.
REQ-008 a_eq_b  input  1  upstream comparator flag: a == b.
REQ-009 a_ls_b  input  1  upstream comparator flag: a < b.
REQ-010 clr  input  1  synchronous clear of counters, error and run tracking.
REQ-011 cnt_gt  output  CNT_W  count of accepted a > b samples.
REQ-012 cnt_eq  output  CNT_W  count of accepted a == b samples.
REQ-013 cnt_ls  output  CNT_W  count of accepted a < b samples.
REQ-014 run_state  output  2  current run relation: 00 IDLE, 01 GT, 10 EQ, 11 LS.
REQ-015 run_match  output  1  single-cycle pulse when the current run reaches RUN_LEN.
REQ-016 out_valid  output  1  single-cycle pulse marking the cycle after an accepted sample.
REQ-017 err  output  1  sticky flag: a valid sample had a non-one-hot flag set.

Function
REQ-018 A sample SHALL be accepted when in_valid=1, clr=0 and exactly one of a_gt_b, a_eq_b, a_ls_b is 1.
REQ-019 An accepted sample SHALL increment the matching counter by 1, saturating at 2^CNT_W-1; the other counters hold.
REQ-020 All outputs SHALL be registered; the effect of a sample accepted in cycle N SHALL be visible in cycle N+1.
REQ-021 out_valid SHALL be 1 in cycle N+1 only if a sample was accepted in cycle N, and 0 otherwise.
REQ-022 The FSM SHALL have states IDLE, GT, EQ and LS, with an internal 4-bit run counter run_cnt.
REQ-023 On an accepted sample whose relation equals run_state, run_cnt SHALL increment, saturating at RUN_LEN.
REQ-024 On an accepted sample whose relation differs from run_state, including from IDLE, run_state SHALL take that relation and run_cnt SHALL become 1.
REQ-025 run_match SHALL pulse for one cycle only on the transition of run_cnt from RUN_LEN-1 to RUN_LEN.
REQ-026 run_match SHALL NOT repeat while the run continues beyond RUN_LEN.
REQ-027 When in_valid=1, clr=0 and the flags are not one-hot (zero or more than one set), err SHALL be set.
REQ-028 Such an illegal sample SHALL leave the counters unchanged, force run_state to IDLE and run_cnt to 0, and produce no out_valid.
REQ-029 err SHALL stay set until clr or reset.
REQ-030 Cycles with in_valid=0 SHALL change no state; the flags are don't-care.
REQ-031 clr=1 SHALL, at the next edge, zero all counters, clear err, and set run_state to IDLE and run_cnt to 0.
REQ-032 clr SHALL take priority over in_valid in the same cycle; that sample is dropped and produces no out_valid.
REQ-033 A saturated counter SHALL hold at its maximum, with no wrap-around, until clr or reset.

Reset
REQ-034 Assertion of rst_n=0 SHALL immediately and asynchronously force cnt_gt, cnt_eq and cnt_ls to 0.
REQ-035 Reset SHALL also force run_state to 00, run_cnt to 0, and run_match, out_valid and err to 0.
REQ-036 Reset asserted mid-run SHALL discard the run in progress; the first sample after release starts a new run with run_cnt=1.
REQ-037 Deassertion of rst_n SHALL be sampled synchronously; the first sample can be accepted on the first clk edge after release.

Verification
REQ-038 Reset, then accept GT, EQ, LS, EQ -> cnt_gt=1, cnt_eq=2, cnt_ls=1, run_state=10, no run_match, out_valid pulse after each sample.
REQ-039 Five consecutive EQ samples with RUN_LEN=3 -> run_match pulses exactly once, in the cycle after the 3rd sample; run_state=10; cnt_eq=5.
REQ-040 GT, GT, then a sample with a_gt_b=1 and a_eq_b=1, then GT -> err=1 and stays set, cnt_gt=3, run_state=01 with run_cnt=1, no run_match.
REQ-041 CNT_W=2 and 5 LS samples -> cnt_ls sticks at 3.
REQ-042 clr with a valid GT in the same cycle -> all counters 0, err=0, run_state=00, and no out_valid in the next cycle.
REQ-043 rst_n pulsed low between clk edges mid-run -> all outputs 0 at once; the next EQ gives run_state=10 with run_cnt=1.
